fifo_notpow2_ctrl: RTL and testbench



---
 rtl/fifo_notpow2_ctrl.sv | 115 +++++++++++
 tb/tb_fifo_notpow2_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_notpow2_ctrl.sv
// FIFO controller for a dual-port RAM of arbitrary depth; read data 1 cycle after accepted read.
// Writes while full are dropped and reads while empty are ignored; FIFO_ALMOST_FLAGS_EN adds almost flags.
module fifo_notpow2_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_COUNT   = 6,
  parameter int AFULL_LEVEL  = DATA_COUNT - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int AW = $clog2(DATA_COUNT),
  localparam int CW = $clog2(DATA_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [CW-1:0]         count,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic [AW-1:0]         ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_datain_a,
  output logic                  ram_we_a,
  output logic                  ram_re_a,
  output logic [AW-1:0]         ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_datain_b,
  output logic                  ram_we_b,
  output logic                  ram_re_b,
  input  logic [DATA_WIDTH-1:0] ram_dataout_b
);

  if (DATA_COUNT < 2 || AFULL_LEVEL > DATA_COUNT || AEMPTY_LEVEL > DATA_COUNT) begin : g_bad_cfg
    $error("fifo_notpow2_ctrl: invalid depth or threshold configuration");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_acc, rd_acc;

  // Pointers wrap at the last entry, not at a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DATA_COUNT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full       = (count_q == CW'(DATA_COUNT));
    empty      = (count_q == '0);
    wr_acc     = wr_en & ~full;
    rd_acc     = rd_en & ~empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  logic almost_full_q, almost_empty_q;

  // Registered from count_d so the flags move on the same edge as count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= CW'(AFULL_LEVEL));
      almost_empty_q <= (count_d <= CW'(AEMPTY_LEVEL));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign count        = count_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = ram_dataout_b;

  assign ram_addr_a   = wr_ptr_q;
  assign ram_datain_a = wr_data;
  assign ram_we_a     = wr_acc;
  assign ram_re_a     = 1'b0;

  assign ram_addr_b   = rd_ptr_q;
  assign ram_datain_b = '0;
  assign ram_we_b     = 1'b0;
  assign ram_re_b     = rd_acc;

endmodule

// File: tb/tb_fifo_notpow2_ctrl.sv
// Directed bench for fifo_notpow2_ctrl (depth 6, width 8) with a behavioural dual-port RAM attached.
module tb_fifo_notpow2_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       full, empty, rd_valid;
  logic [7:0] rd_data;
  logic [2:0] count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif
  logic [2:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_datain_a, ram_datain_b, ram_dataout_b;
  logic       ram_we_a, ram_re_a, ram_we_b, ram_re_b;

  int tests = 0;
  int fails = 0;
  int exp_wp = 0;
  int exp_rp = 0;

  always #5 clk = ~clk;

  fifo_notpow2_ctrl #(.DATA_WIDTH(8), .DATA_COUNT(6)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .count(count),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .ram_addr_a(ram_addr_a), .ram_datain_a(ram_datain_a), .ram_we_a(ram_we_a), .ram_re_a(ram_re_a),
    .ram_addr_b(ram_addr_b), .ram_datain_b(ram_datain_b), .ram_we_b(ram_we_b), .ram_re_b(ram_re_b),
    .ram_dataout_b(ram_dataout_b)
  );

  // Behavioural RAM: registered read output held while ram_re_b is low.
  logic [7:0] mem [0:5];
  always_ff @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_datain_a;
    if (ram_re_b) ram_dataout_b <= mem[ram_addr_b];
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    tests++; if ({ram_re_a, ram_we_b, ram_datain_b} !== 10'd0) begin fails++; $display("FAIL reset_tied got %h exp 0", {ram_re_a, ram_we_b, ram_datain_b}); end
    reset = 1'b0;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      tests++; if (count !== 3'(i)) begin fails++; $display("FAIL fill_count got %0d exp %0d", count, i); end
      tests++; if (empty !== 1'b0) begin fails++; $display("FAIL fill_empty got %b exp 0", empty); end
    end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", full); end
    wr_en = 1'b1; wr_data = 8'hFF; #1;
    tests++; if (ram_we_a !== 1'b0) begin fails++; $display("FAIL drop_we got %b exp 0", ram_we_a); end
    cyc(1'b1, 8'hFF, 1'b0);
    tests++; if (count !== 3'd6) begin fails++; $display("FAIL drop_count got %0d exp 6", count); end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL drain_valid got %b exp 1", rd_valid); end
      tests++; if (rd_data !== 8'(i)) begin fails++; $display("FAIL drain_data got %h exp %h", rd_data, 8'(i)); end
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b exp 1", empty); end
    rd_en = 1'b1; #1;
    tests++; if (ram_re_b !== 1'b0) begin fails++; $display("FAIL empty_re got %b exp 0", ram_re_b); end
    cyc(1'b0, 8'h00, 1'b1);
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b exp 0", rd_valid); end
    tests++; if (rd_data !== 8'd6) begin fails++; $display("FAIL hold_data got %h exp 06", rd_data); end
  endtask

  task automatic test_wrap;
    exp_wp = 0; exp_rp = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + i); #1;
      tests++; if (ram_addr_a !== 3'(exp_wp)) begin fails++; $display("FAIL wrap_waddr got %0d exp %0d", ram_addr_a, exp_wp); end
      cyc(1'b1, 8'(8'hA0 + i), 1'b0);
      exp_wp = (exp_wp == 5) ? 0 : exp_wp + 1;
      rd_en = 1'b1; #1;
      tests++; if (ram_addr_b !== 3'(exp_rp)) begin fails++; $display("FAIL wrap_raddr got %0d exp %0d", ram_addr_b, exp_rp); end
      cyc(1'b0, 8'h00, 1'b1);
      exp_rp = (exp_rp == 5) ? 0 : exp_rp + 1;
      tests++; if (rd_data !== 8'(8'hA0 + i)) begin fails++; $display("FAIL wrap_data got %h exp %h", rd_data, 8'(8'hA0 + i)); end
    end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_count got %0d exp 0", count); end
  endtask

  task automatic test_simul_mid;
    logic [7:0] exp_q [0:6];
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b1);
      tests++; if (count !== 3'd3) begin fails++; $display("FAIL mid_count got %0d exp 3", count); end
      tests++; if (rd_data !== exp_q[i]) begin fails++; $display("FAIL mid_data got %h exp %h", rd_data, exp_q[i]); end
    end
    for (int i = 4; i < 7; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      tests++; if (rd_data !== exp_q[i]) begin fails++; $display("FAIL mid_drain got %h exp %h", rd_data, exp_q[i]); end
    end
  endtask

  task automatic test_simul_bounds;
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    tests++; if (count !== 3'd5) begin fails++; $display("FAIL full_both_count got %0d exp 5", count); end
    tests++; if (rd_data !== 8'h50) begin fails++; $display("FAIL full_both_data got %h exp 50", rd_data); end
    for (int i = 1; i < 6; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      tests++; if (rd_data !== 8'(8'h50 + i)) begin fails++; $display("FAIL full_drain got %h exp %h", rd_data, 8'(8'h50 + i)); end
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_drain_empty got %b exp 1", empty); end
    cyc(1'b1, 8'h77, 1'b1);
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL empty_both_count got %0d exp 1", count); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL empty_both_valid got %b exp 0", rd_valid); end
    cyc(1'b0, 8'h00, 1'b1);
    tests++; if (rd_data !== 8'h77) begin fails++; $display("FAIL empty_both_data got %h exp 77", rd_data); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL rst_pre_count got %0d exp 4", count); end
    rd_en = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", rd_valid); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", empty); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    reset = 1'b0;
    cyc(1'b1, 8'h99, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL rst_new_valid got %b exp 1", rd_valid); end
    tests++; if (rd_data !== 8'h99) begin fails++; $display("FAIL rst_new_data got %h exp 99", rd_data); end
  endtask

`ifdef FIFO_ALMOST_FLAGS_EN
  task automatic test_almost;
    logic exp_af [1:6];
    logic exp_ae [1:6];
    exp_af = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ae = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests++; if ({almost_full, almost_empty} !== 2'b01) begin fails++; $display("FAIL almost_init got %b exp 01", {almost_full, almost_empty}); end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      tests++; if (almost_full !== exp_af[i]) begin fails++; $display("FAIL afull got %b exp %b at %0d", almost_full, exp_af[i], i); end
      tests++; if (almost_empty !== exp_ae[i]) begin fails++; $display("FAIL aempty got %b exp %b at %0d", almost_empty, exp_ae[i], i); end
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
    tests++; if ({almost_full, almost_empty} !== 2'b01) begin fails++; $display("FAIL almost_end got %b exp 01", {almost_full, almost_empty}); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul_mid();
    test_simul_bounds();
    test_reset_mid();
`ifdef FIFO_ALMOST_FLAGS_EN
    test_almost();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
